// File: rtl/pool_sequencer_pkg.sv
// Shared types and defaults for the max-pooling sequencer and the pooler top.
package pool_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SEL_FLOOR  = 2'b00;
  localparam logic [1:0] SEL_RUNMAX = 2'b01;
  localparam logic [1:0] SEL_SHIFT  = 2'b10;

  localparam int DEF_M = 12;
  localparam int DEF_P = 3;

endpackage

// File: rtl/pool_sequencer_if.sv
// Control bundle between the pooling sequencer (master) and the datapath/stimulus side (slave).
interface pool_sequencer_if;

  logic       ce;
  logic       start;
  logic [1:0] sel;
  logic       rst_m;
  logic       load_sr;
  logic       global_rst;
  logic       valid_op;
  logic       end_op;
  logic       busy;

  modport master (
    input  ce, start,
    output sel, rst_m, load_sr, global_rst, valid_op, end_op, busy
  );

  modport slave (
    output ce, start,
    input  sel, rst_m, load_sr, global_rst, valid_op, end_op, busy
  );

endinterface

// File: rtl/pool_win_counter.sv
// Mod-P position counter, kept as a down-counter of pixels remaining in the window.
module pool_win_counter #(
  parameter int P = 3
) (
  input  logic clk,
  input  logic master_rst,
  input  logic clr,
  input  logic adv,
  output logic first,
  output logic last
);

  localparam int PW = (P > 1) ? $clog2(P) : 1;

  logic [PW-1:0] remain;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (master_rst || clr) begin
      remain <= PW'(P - 1);
    end else if (adv) begin
      remain <= (remain == '0) ? PW'(P - 1) : remain - PW'(1);
    end
  end

  assign first = (remain == PW'(P - 1));
  assign last  = (remain == '0);

endmodule

// File: rtl/pool_sequencer.sv
// Raster-order pixel sequencer steering the streaming P x P max-pooling datapath.
module pool_sequencer
  import pool_sequencer_pkg::*;
#(
  parameter int M  = DEF_M,
  parameter int P  = DEF_P,
  parameter int CW = $clog2(M)
) (
  input  logic              clk,
  input  logic              master_rst,
  pool_sequencer_if.master  bus
);

  state_t        state;
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          accept;
  logic          col_last;
  logic          row_last;
  logic          frame_last;
  logic          win_last;
  logic          wc_first, wc_last;
  logic          wr_first, wr_last;

  assign accept     = bus.ce && (state == RUN);
  assign col_last   = (col == CW'(M - 1));
  assign row_last   = (row == CW'(M - 1));
  assign frame_last = accept && col_last && row_last;
  assign win_last   = accept && wc_last && wr_last;

  pool_win_counter #(.P(P)) u_wc (
    .clk        (clk),
    .master_rst (master_rst),
    .clr        (state != RUN),
    .adv        (accept),
    .first      (wc_first),
    .last       (wc_last)
  );

  pool_win_counter #(.P(P)) u_wr (
    .clk        (clk),
    .master_rst (master_rst),
    .clr        (state != RUN),
    .adv        (accept && col_last),
    .first      (wr_first),
    .last       (wr_last)
  );

  // Counters sit at the frame origin whenever the sequencer is not running.
  always_ff @(posedge clk) begin
    if (master_rst || (state != RUN)) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + CW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Mux and shifter controls act in the same cycle as the pixel they steer.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    bus.sel     = SEL_FLOOR;
    bus.load_sr = 1'b0;
    if (accept) begin
      if (wc_first) begin
        bus.sel = wr_first ? SEL_FLOOR : SEL_SHIFT;
      end else begin
        bus.sel = SEL_RUNMAX;
      end
      bus.load_sr = wc_last && !wr_last;
    end
  end

  always_ff @(posedge clk) begin
    if (master_rst) begin
      state          <= IDLE;
      bus.valid_op   <= 1'b0;
      bus.end_op     <= 1'b0;
      bus.busy       <= 1'b0;
      bus.rst_m      <= 1'b1;
      bus.global_rst <= 1'b1;
    end else begin
      bus.valid_op <= win_last;
      bus.end_op   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state          <= RUN;
            bus.busy       <= 1'b1;
            bus.rst_m      <= 1'b0;
            bus.global_rst <= 1'b0;
          end
        end
        RUN: begin
          if (frame_last) begin
            state          <= DONE;
            bus.end_op     <= 1'b1;
            bus.busy       <= 1'b0;
            bus.rst_m      <= 1'b1;
            bus.global_rst <= 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            state          <= RUN;
            bus.busy       <= 1'b1;
            bus.rst_m      <= 1'b0;
            bus.global_rst <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
